// File: rtl/sqwave_pkg.sv
// ----------------------------------------------------------------------------
// sqwave_pkg
//   Shared definitions for the multi-channel square-wave generator.
//   - state_t    : per-channel FSM state (IDLE / HIGH / LOW)
//   - MODE_*     : encoding of the one-shot bit in a shadow word
//   - max_int    : helper used to size the per-channel down-counter
// ----------------------------------------------------------------------------
package sqwave_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   localparam logic MODE_CONT    = 1'b0;
   localparam logic MODE_ONESHOT = 1'b1;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sqwave_chan.sv
// ----------------------------------------------------------------------------
// sqwave_chan
//   One square-wave channel: shadow word, active word, IDLE/HIGH/LOW FSM and
//   a down-counter. New durations sit in the shadow word until a period
//   boundary copies them into the active word, so the output never glitches.
//
//   Ports
//     clk, reset      : clock, synchronous active-high reset
//     en              : level-sensitive run enable
//     wr              : shadow write strobe (already decoded for this channel)
//     wr_rise/wr_fall : high/low durations in clk cycles
//     wr_oneshot      : MODE_ONESHOT or MODE_CONT
//     clk_out         : registered square-wave output
//     period_done     : registered pulse on the last cycle of a period
//     state           : current FSM state (also used by the top for busy)
//
//   Handshake: wr is a valid-only strobe with no ready; a write is accepted on
//   every edge at which it is high, and the last write before a boundary wins.
// ----------------------------------------------------------------------------
module sqwave_chan
   import sqwave_pkg::*;
#(
   parameter int RISE_W = 16,
   parameter int FALL_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              wr,
   input  logic [RISE_W-1:0] wr_rise,
   input  logic [FALL_W-1:0] wr_fall,
   input  logic              wr_oneshot,
   output logic              clk_out,
   output logic              period_done,
   output state_t            state
);

   localparam int CNT_W = max_int(RISE_W, FALL_W);

   typedef struct packed {
      logic [RISE_W-1:0] rise;
      logic [FALL_W-1:0] fall;
      logic              oneshot;
   } word_t;

   word_t            shadow, active, nxt_active;
   logic [CNT_W-1:0] cnt, nxt_cnt;
   state_t           nxt_state;
   state_t           sh_state;
   logic [CNT_W-1:0] sh_cnt;
   logic             lock, nxt_lock;
   logic             boundary;
   logic             nxt_done;

   // Where a period loaded from the shadow word starts. A zero rise skips
   // straight to LOW; an all-zero word means "do not run".
   always_comb begin
      sh_state = ST_IDLE;
      sh_cnt   = CNT_W'(shadow.fall) - CNT_W'(1);
      if (shadow.rise != '0) begin
         sh_state = ST_HIGH;
         sh_cnt   = CNT_W'(shadow.rise) - CNT_W'(1);
      end else if (shadow.fall != '0) begin
         sh_state = ST_LOW;
      end
   end

   // Last cycle of a period: end of LOW, or end of HIGH when there is no LOW.
   assign boundary = (cnt == '0) &&
                     ((state == ST_LOW) || (state == ST_HIGH && active.fall == '0));

   // lock holds off a one-shot restart until en has been seen low again.
   always_comb begin
      nxt_state  = state;
      nxt_cnt    = cnt;
      nxt_active = active;
      nxt_lock   = lock;
      if (!en) nxt_lock = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en && sh_state != ST_IDLE &&
                (shadow.oneshot == MODE_CONT || !lock)) begin
               nxt_active = shadow;
               nxt_state  = sh_state;
               nxt_cnt    = sh_cnt;
            end
         end
         ST_HIGH, ST_LOW: begin
            if (!en) begin
               nxt_state = ST_IDLE;
            end else if (boundary) begin
               if (active.oneshot == MODE_ONESHOT) begin
                  nxt_state = ST_IDLE;
                  nxt_lock  = 1'b1;
               end else begin
                  // Pre-edge shadow; an all-zero shadow lands in IDLE.
                  nxt_active = shadow;
                  nxt_state  = sh_state;
                  nxt_cnt    = sh_cnt;
               end
            end else if (cnt == '0) begin
               nxt_state = ST_LOW;
               nxt_cnt   = CNT_W'(active.fall) - CNT_W'(1);
            end else begin
               nxt_cnt = cnt - CNT_W'(1);
            end
         end
         default: nxt_state = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   assign nxt_done = (nxt_cnt == '0) &&
                     ((nxt_state == ST_LOW) ||
                      (nxt_state == ST_HIGH && nxt_active.fall == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         shadow      <= '0;
         active      <= '0;
         lock        <= 1'b0;
         clk_out     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         active      <= nxt_active;
         lock        <= nxt_lock;
         clk_out     <= (nxt_state == ST_HIGH);
         period_done <= nxt_done;
         if (wr) shadow <= '{rise: wr_rise, fall: wr_fall, oneshot: wr_oneshot};
      end
   end

endmodule

// File: rtl/sqwave_gen_multi.sv
// ----------------------------------------------------------------------------
// sqwave_gen_multi
//   NCH independent square-wave channels with double-buffered durations.
//
//   Ports
//     clk, reset    : clock, synchronous active-high reset
//     en[NCH]       : per-channel run enable
//     load_valid    : shadow write strobe (no backpressure)
//     load_ch       : channel addressed by the write; values >= NCH are ignored
//     load_rise     : high-phase cycles
//     load_fall     : low-phase cycles
//     load_oneshot  : 1 = one-shot, 0 = continuous
//     clk_out[NCH]  : registered square-wave outputs
//     period_done[NCH] : pulse on the last cycle of each completed period
//     busy[NCH]     : channel is in HIGH or LOW
// ----------------------------------------------------------------------------
module sqwave_gen_multi
   import sqwave_pkg::*;
#(
   parameter int NCH    = 4,
   parameter int RISE_W = 16,
   parameter int FALL_W = 10,
   localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NCH-1:0]    en,
   input  logic              load_valid,
   input  logic [CH_W-1:0]   load_ch,
   input  logic [RISE_W-1:0] load_rise,
   input  logic [FALL_W-1:0] load_fall,
   input  logic              load_oneshot,
   output logic [NCH-1:0]    clk_out,
   output logic [NCH-1:0]    period_done,
   output logic [NCH-1:0]    busy
);

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic   wr;
      state_t st;

      // Only indices 0..NCH-1 exist, so an out-of-range load_ch matches none.
      assign wr = load_valid && (load_ch == CH_W'(gi));

      sqwave_chan #(
         .RISE_W (RISE_W),
         .FALL_W (FALL_W)
      ) u_chan (
         .clk         (clk),
         .reset       (reset),
         .en          (en[gi]),
         .wr          (wr),
         .wr_rise     (load_rise),
         .wr_fall     (load_fall),
         .wr_oneshot  (load_oneshot),
         .clk_out     (clk_out[gi]),
         .period_done (period_done[gi]),
         .state       (st)
      );

      assign busy[gi] = (st != ST_IDLE);
   end

endmodule

// File: tb/tb_sqwave_gen_multi.sv
// ----------------------------------------------------------------------------
// tb_sqwave_gen_multi
//   Self-checking bench for sqwave_gen_multi with NCH=3 (so load_ch=3 is an
//   out-of-range address). Expected per-cycle {clk_out, period_done, busy}
//   words are built from the period shape and queued; each cycle the DUT
//   outputs are sampled 1 time unit after the rising edge and popped/compared.
// ----------------------------------------------------------------------------
module tb_sqwave_gen_multi;

   localparam int NCH    = 3;
   localparam int RISE_W = 16;
   localparam int FALL_W = 10;
   localparam int CH_W   = 2;
   localparam int IW     = 3 * NCH;

   logic              clk = 1'b0;
   logic              reset;
   logic [NCH-1:0]    en;
   logic              load_valid;
   logic [CH_W-1:0]   load_ch;
   logic [RISE_W-1:0] load_rise;
   logic [FALL_W-1:0] load_fall;
   logic              load_oneshot;
   logic [NCH-1:0]    clk_out;
   logic [NCH-1:0]    period_done;
   logic [NCH-1:0]    busy;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   sqwave_gen_multi #(
      .NCH    (NCH),
      .RISE_W (RISE_W),
      .FALL_W (FALL_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .en           (en),
      .load_valid   (load_valid),
      .load_ch      (load_ch),
      .load_rise    (load_rise),
      .load_fall    (load_fall),
      .load_oneshot (load_oneshot),
      .clk_out      (clk_out),
      .period_done  (period_done),
      .busy         (busy)
   );

   // ---------------- scoreboard ----------------
   logic [IW-1:0] exp_q[$];
   int n_checks = 0;
   int n_errors = 0;

   function automatic logic [IW-1:0] mk(input int ch, input logic c,
                                        input logic p, input logic b);
      logic [NCH-1:0] cv, pv, bv;
      cv = '0; pv = '0; bv = '0;
      cv[ch] = c; pv[ch] = p; bv[ch] = b;
      return {cv, pv, bv};
   endfunction

   function automatic logic [IW-1:0] outs();
      return {clk_out, period_done, busy};
   endfunction

   task automatic push_period(input int ch, input int r, input int f);
      for (int i = 0; i < r; i++) exp_q.push_back(mk(ch, 1'b1, (f == 0) && (i == r - 1), 1'b1));
      for (int i = 0; i < f; i++) exp_q.push_back(mk(ch, 1'b0, i == f - 1, 1'b1));
   endtask

   task automatic push_idle(input int n);
      for (int i = 0; i < n; i++) exp_q.push_back('0);
   endtask

   task automatic check(input string name, input int idx,
                        input logic [IW-1:0] act, input logic [IW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s[%0d]: got {clk_out,period_done,busy}=%b expected %b",
                  name, idx, act, exp);
      end
   endtask

   task automatic pop_check(input string name, input int idx);
      logic [IW-1:0] e;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s[%0d]: scoreboard queue empty", name, idx);
      end else begin
         e = exp_q.pop_front();
         check(name, idx, outs(), e);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      en         = '0;
      load_valid = 1'b0;
      step();
      check("reset", 0, outs(), '0);
      reset = 1'b0;
      exp_q.delete();
   endtask

   task automatic set_load(input int ch, input int r, input int f, input logic os);
      load_valid   = 1'b1;
      load_ch      = CH_W'(ch);
      load_rise    = RISE_W'(r);
      load_fall    = FALL_W'(f);
      load_oneshot = os;
   endtask

   task automatic load(input int ch, input int r, input int f, input logic os);
      set_load(ch, r, f, os);
      step();
      load_valid = 1'b0;
   endtask

   // Continuous run of ncyc cycles; periods with index < sw use r/f, later
   // ones r2/f2, which are written during cycle ld (ld < 0: no write).
   task automatic run_vec(input string name, input int ch, input int r, input int f,
                          input int ncyc, input int sw, input int r2, input int f2,
                          input int ld);
      int rr, ff;
      logic [IW-1:0] e;
      do_reset();
      load(ch, r, f, 1'b0);
      for (int p = 0; exp_q.size() < ncyc + 1; p++)
         push_period(ch, (p < sw) ? r : r2, (p < sw) ? f : f2);
      en[ch] = 1'b1;
      for (int i = 0; i < ncyc; i++) begin
         step();
         load_valid = 1'b0;
         pop_check(name, i);
         if (i == ld) set_load(ch, r2, f2, 1'b0);
      end
      // Drop en: idle next edge with no period_done, shadow retained.
      en[ch] = 1'b0;
      load_valid = 1'b0;
      step();
      check({name, "_en_off"}, 0, outs(), '0);
      rr = (ld >= 0) ? r2 : r;
      ff = (ld >= 0) ? f2 : f;
      if (rr != 0) e = mk(ch, 1'b1, (ff == 0) && (rr == 1), 1'b1);
      else         e = mk(ch, 1'b0, ff == 1, 1'b1);
      en[ch] = 1'b1;
      step();
      check({name, "_restart"}, 0, outs(), e);
      en[ch] = 1'b0;
      step();
      check({name, "_stop"}, 0, outs(), '0);
      exp_q.delete();
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      string name;
      int ch, r, f, ncyc, sw, r2, f2, ld;
   } vec_t;

   vec_t vecs[7];

   initial begin
      vecs[0] = '{"ch0_4_2",        0, 4, 2, 20, 99, 4, 2, -1};
      vecs[1] = '{"ch1_3_3_to_1_1", 1, 3, 3, 14,  1, 1, 1,  1};
      vecs[2] = '{"ch0_2_2_to_6_1", 0, 2, 2, 20,  2, 6, 1,  3};
      vecs[3] = '{"ch0_rise0_f4",   0, 0, 4, 13, 99, 0, 4, -1};
      vecs[4] = '{"ch2_1_1",        2, 1, 1,  9, 99, 1, 1, -1};
      vecs[5] = '{"ch1_3_0",        1, 3, 0, 10, 99, 3, 0, -1};
      vecs[6] = '{"ch2_2_5",        2, 2, 5, 15, 99, 2, 5, -1};

      reset = 1'b1; en = '0; load_valid = 1'b0; load_ch = '0;
      load_rise = '0; load_fall = '0; load_oneshot = 1'b0;

      // Reset in the middle of a running 5/3 period.
      do_reset();
      load(0, 5, 3, 1'b0);
      en[0] = 1'b1;
      push_period(0, 5, 3);
      for (int i = 0; i < 3; i++) begin step(); pop_check("pre_reset", i); end
      reset = 1'b1;
      step();
      check("reset_mid", 0, outs(), '0);
      reset = 1'b0;
      exp_q.delete();
      step();
      check("reset_shadow_clear", 0, outs(), '0);
      en[0] = 1'b0;
      load(0, 5, 3, 1'b0);
      en[0] = 1'b1;
      push_period(0, 5, 3);
      for (int i = 0; i < 8; i++) begin step(); pop_check("post_reset", i); end
      en[0] = 1'b0;
      step();
      check("post_reset_off", 0, outs(), '0);

      // Table-driven continuous runs, including mid-period and boundary writes.
      for (int v = 0; v < 7; v++)
         run_vec(vecs[v].name, vecs[v].ch, vecs[v].r, vecs[v].f, vecs[v].ncyc,
                 vecs[v].sw, vecs[v].r2, vecs[v].f2, vecs[v].ld);

      // One-shot 7/5 on ch2 with en held high, then an en 1->0->1 retrigger.
      do_reset();
      load(2, 7, 5, 1'b1);
      en[2] = 1'b1;
      push_period(2, 7, 5);
      push_idle(5);
      for (int i = 0; i < 17; i++) begin step(); pop_check("oneshot_a", i); end
      en[2] = 1'b0;
      step();
      check("oneshot_en_low", 0, outs(), '0);
      en[2] = 1'b1;
      push_period(2, 7, 5);
      push_idle(4);
      for (int i = 0; i < 16; i++) begin step(); pop_check("oneshot_b", i); end
      en[2] = 1'b0;
      exp_q.delete();

      // rise=fall=0 never leaves IDLE.
      do_reset();
      load(2, 0, 0, 1'b0);
      en[2] = 1'b1;
      push_idle(4);
      for (int i = 0; i < 4; i++) begin step(); pop_check("zero_word", i); end

      // Out-of-range channel write changes nothing.
      do_reset();
      load(3, 2, 2, 1'b0);
      en = '1;
      push_idle(4);
      for (int i = 0; i < 4; i++) begin step(); pop_check("bad_ch", i); end

      // rise=65535 fall=0: constant high, period_done every 65535 cycles.
      do_reset();
      load(1, 65535, 0, 1'b0);
      en[1] = 1'b1;
      push_period(1, 65535, 0);
      for (int i = 0; i < 3; i++) exp_q.push_back(mk(1, 1'b1, 1'b0, 1'b1));
      for (int i = 0; i < 65538; i++) begin step(); pop_check("rise_max", i); end
      en[1] = 1'b0;
      step();
      check("rise_max_off", 0, outs(), '0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
